// File: rtl/mem_access_if.sv
// Handshake and memory-port bundle between the MEM-stage pipeline, the load/store
// sequencer and the word-indexed data memory.
interface mem_access_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;

   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_data;
   logic              resp_err;

   logic [31:0]       mem_address;
   logic [31:0]       mem_data_in;
   logic [1:0]        mem_write;
   logic              mem_read;
   logic [31:0]       mem_data;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, resp_ready, mem_data,
      input  req_ready, resp_valid, resp_data, resp_err,
             mem_address, mem_data_in, mem_write, mem_read
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, resp_ready, mem_data,
      output req_ready, resp_valid, resp_data, resp_err,
             mem_address, mem_data_in, mem_write, mem_read
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the word-indexed data memory; sub-word stores are read-modify-write.
// Optional misalignment trap: define MEM_ACCESS_MISALIGN_TRAP_EN.
//
// state | meaning
// IDLE  | ready to accept one request
// READ  | addressed word presented with mem_read, sampled at end of cycle
// WRITE | single-cycle full-word store (mem_write = 01)
// RESP  | load result or error held until writeback accepts it
module mem_access_unit #(
   parameter int ADDR_W         = 32,
   parameter int MEM_WORDS_LOG2 = 10
) (
   input logic         clk,
   input logic         reset_n,
   mem_access_if.slave bus
);

   localparam logic [2:0] OP_LW  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LHU = 3'b010;
   localparam logic [2:0] OP_LB  = 3'b011;
   localparam logic [2:0] OP_LBU = 3'b100;
   localparam logic [2:0] OP_SW  = 3'b101;
   localparam logic [2:0] OP_SH  = 3'b110;
   localparam logic [2:0] OP_SB  = 3'b111;

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t                    state;
   logic [2:0]                op_q;
   logic [1:0]                off_q;
   logic [15:0]               wdata_q;
   logic                      resp_valid_q;
   logic [31:0]               resp_data_q;
   logic [31:0]               mem_address_q;
   logic [31:0]               mem_data_in_q;
   logic [MEM_WORDS_LOG2-1:0] widx;
   logic                      unused_addr_hi;

   // Upper address bits are dropped so accesses wrap modulo the memory depth.
   assign widx           = bus.req_addr[MEM_WORDS_LOG2+1:2];
   assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:MEM_WORDS_LOG2+2];

   function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] w);
      logic [15:0] h;
      logic [31:0] sh;
      logic [7:0]  b;
      logic [31:0] r;
      h  = off[1] ? w[31:16] : w[15:0];
      sh = w >> {off, 3'b000};
      b  = sh[7:0];
      case (op)
         OP_LH:   r = {{16{h[15]}}, h};
         OP_LHU:  r = {16'h0000, h};
         OP_LB:   r = {{24{b[7]}}, b};
         OP_LBU:  r = {24'h000000, b};
         default: r = w;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge(input logic [2:0] op, input logic [1:0] off,
                                         input logic [31:0] w, input logic [15:0] d);
      logic [31:0] r;
      r = w;
      if (op == OP_SH) begin
         if (off[1]) r[31:16] = d;
         else        r[15:0]  = d;
      end else begin
         case (off)
            2'd0:    r[7:0]   = d[7:0];
            2'd1:    r[15:8]  = d[7:0];
            2'd2:    r[23:16] = d[7:0];
            default: r[31:24] = d[7:0];
         endcase
      end
      return r;
   endfunction

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   logic resp_err_q;

   function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
      logic m;
      case (op)
         OP_LW, OP_SW:         m = (off != 2'b00);
         OP_LH, OP_LHU, OP_SH: m = off[0];
         default:              m = 1'b0;
      endcase
      return m;
   endfunction

   assign bus.resp_err = resp_err_q;
`else
   assign bus.resp_err = 1'b0;
`endif

   // Strobes are gated by reset so a WRITE cycle coincident with reset stays silent.
   assign bus.req_ready   = reset_n && (state == IDLE);
   assign bus.mem_read    = reset_n && (state == READ);
   assign bus.mem_write   = {1'b0, reset_n && (state == WRITE)};
   assign bus.mem_address = mem_address_q;
   assign bus.mem_data_in = mem_data_in_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_data   = resp_data_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= IDLE;
         op_q          <= OP_LW;
         off_q         <= 2'b00;
         wdata_q       <= 16'h0000;
         resp_valid_q  <= 1'b0;
         resp_data_q   <= 32'h0;
         mem_address_q <= 32'h0;
         mem_data_in_q <= 32'h0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
         resp_err_q    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  op_q    <= bus.req_op;
                  off_q   <= bus.req_addr[1:0];
                  wdata_q <= bus.req_wdata[15:0];
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                  if (misaligned(bus.req_op, bus.req_addr[1:0])) begin
                     resp_valid_q <= 1'b1;
                     resp_data_q  <= 32'h0;
                     resp_err_q   <= 1'b1;
                     state        <= RESP;
                  end else
`endif
                  if (bus.req_op == OP_SW) begin
                     mem_address_q <= {{(32-MEM_WORDS_LOG2){1'b0}}, widx};
                     mem_data_in_q <= bus.req_wdata;
                     state         <= WRITE;
                  end else begin
                     mem_address_q <= {{(32-MEM_WORDS_LOG2){1'b0}}, widx};
                     state         <= READ;
                  end
               end
            end
            READ: begin
               if (op_q == OP_SH || op_q == OP_SB) begin
                  mem_data_in_q <= merge(op_q, off_q, bus.mem_data, wdata_q);
                  state         <= WRITE;
               end else begin
                  resp_data_q  <= extract(op_q, off_q, bus.mem_data);
                  resp_valid_q <= 1'b1;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                  resp_err_q   <= 1'b0;
`endif
                  state        <= RESP;
               end
            end
            WRITE: begin
               state <= IDLE;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                  resp_err_q   <= 1'b0;
`endif
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of load/store vectors against a behavioural
// word memory, plus hand sequences for reset, response stall, misalignment and mid-op reset.
module tb_mem_access_unit;

   localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011,
                          LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

   logic clk = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad = 0;
   int   wr_cnt = 0;
   int   rd_cnt = 0;
   int   badcode = 0;
   logic [31:0] wr_addr = 32'h0;
   logic [31:0] mem [0:1023];

   mem_access_if #(.ADDR_W(32)) bus ();

   mem_access_unit #(.ADDR_W(32), .MEM_WORDS_LOG2(10)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   assign bus.mem_data = mem[bus.mem_address[9:0]];

   always @(posedge clk) begin
      if (bus.mem_write == 2'b01) begin
         mem[bus.mem_address[9:0]] <= bus.mem_data_in;
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= bus.mem_address;
      end
      if (bus.mem_write[1]) badcode <= badcode + 1;
      if (bus.mem_read) rd_cnt <= rd_cnt + 1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] data, output logic err, output int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: req_ready never rose, got 0 expected 1");
      end
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      lat  = 0;
      data = 32'h0;
      err  = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.resp_valid) begin
            data = bus.resp_data;
            err  = bus.resp_err;
            lat  = i;
            break;
         end
         if (bus.req_ready) begin
            lat = i;
            break;
         end
      end
      if (lat == 0) begin
         total++;
         bad++;
         $display("FAIL txn_timeout: no completion within 20 cycles, got 0 expected nonzero");
      end
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t v[$];

   function automatic void add(input logic [2:0] op, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] exp);
      int l;
      l = (op == SH || op == SB) ? 3 : 2;
      v.push_back('{op, addr, wd, exp, l});
   endfunction

   logic [31:0] d, held, pre;
   logic        e;
   int          lat, w0, r0;

   initial begin
      add(SW,  32'h10,   32'hDEADBEEF, 32'h0);
      add(LW,  32'h10,   32'h0,        32'hDEADBEEF);
      add(SW,  32'h10,   32'h11223344, 32'h0);
      add(SB,  32'h13,   32'hAAAAAA80, 32'h0);
      add(LW,  32'h10,   32'h0,        32'h80223344);
      add(LB,  32'h13,   32'h0,        32'hFFFFFF80);
      add(LBU, 32'h13,   32'h0,        32'h00000080);
      add(SW,  32'h10,   32'h11223344, 32'h0);
      add(SH,  32'h12,   32'h1234BEEF, 32'h0);
      add(LW,  32'h10,   32'h0,        32'hBEEF3344);
      add(LH,  32'h12,   32'h0,        32'hFFFFBEEF);
      add(LHU, 32'h10,   32'h0,        32'h00003344);
      add(LH,  32'h10,   32'h0,        32'h00003344);
      add(LB,  32'h10,   32'h0,        32'h00000044);
      add(LB,  32'h11,   32'h0,        32'h00000033);
      add(LBU, 32'h12,   32'h0,        32'h000000EF);
      add(LB,  32'h12,   32'h0,        32'hFFFFFFEF);
      add(SW,  32'h1010, 32'hCAFEF00D, 32'h0);
      add(LW,  32'h10,   32'h0,        32'hCAFEF00D);
      add(SB,  32'h10,   32'h0000007F, 32'h0);
      add(LB,  32'h10,   32'h0,        32'h0000007F);
      add(SH,  32'h10,   32'h00008001, 32'h0);
      add(LH,  32'h10,   32'h0,        32'hFFFF8001);
      add(LHU, 32'h12,   32'h0,        32'h0000CAFE);
      add(LW,  32'h10,   32'h0,        32'hCAFE8001);
      add(SW,  32'hFFC,  32'h01020304, 32'h0);
      add(LW,  32'hFFC,  32'h0,        32'h01020304);
      add(LBU, 32'hFFF,  32'h0,        32'h00000001);
      add(LH,  32'hFFE,  32'h0,        32'h00000102);
      add(SW,  32'h0,    32'hFFFFFFFF, 32'h0);
      add(LBU, 32'h1,    32'h0,        32'h000000FF);
      add(LH,  32'h0,    32'h0,        32'hFFFFFFFF);
      add(LW,  32'hFFC,  32'h0,        32'h01020304);

      // Reset held with a request pending
      reset_n        = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_op     = SW;
      bus.req_addr   = 32'h10;
      bus.req_wdata  = 32'h12345678;
      bus.resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready",   {31'h0, bus.req_ready},  32'h0);
      chk("rst_resp_valid",  {31'h0, bus.resp_valid}, 32'h0);
      chk("rst_resp_data",   bus.resp_data,           32'h0);
      chk("rst_resp_err",    {31'h0, bus.resp_err},   32'h0);
      chk("rst_mem_address", bus.mem_address,         32'h0);
      chk("rst_mem_data_in", bus.mem_data_in,         32'h0);
      chk("rst_mem_write",   {30'h0, bus.mem_write},  32'h0);
      chk("rst_mem_read",    {31'h0, bus.mem_read},   32'h0);
      chk("rst_no_activity", wr_cnt + rd_cnt,         32'h0);
      reset_n       = 1'b1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", {31'h0, bus.req_ready}, 32'h1);

      // Table-driven vectors
      foreach (v[i]) begin
         w0 = wr_cnt;
         r0 = rd_cnt;
         txn(v[i].op, v[i].addr, v[i].wd, d, e, lat);
         chk($sformatf("v%0d_lat", i), lat, v[i].lat);
         if (v[i].op >= SW) begin
            chk($sformatf("v%0d_wr_count", i), wr_cnt - w0, 32'd1);
            chk($sformatf("v%0d_wr_addr", i), wr_addr, (v[i].addr >> 2) & 32'h3FF);
         end else begin
            chk($sformatf("v%0d_data", i), d, v[i].exp);
            chk($sformatf("v%0d_err", i), {31'h0, e}, 32'h0);
            chk($sformatf("v%0d_no_write", i), wr_cnt - w0, 32'd0);
            chk($sformatf("v%0d_one_read", i), rd_cnt - r0, 32'd1);
         end
      end

      // Response stall: writeback holds off for 5 cycles
      txn(SW, 32'h10, 32'h5A5AA5A5, d, e, lat);
      bus.resp_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = LW;
      bus.req_addr  = 32'h10;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("stall_t1_valid", {31'h0, bus.resp_valid}, 32'h0);
      chk("stall_t1_read",  {31'h0, bus.mem_read},   32'h1);
      chk("stall_t1_addr",  bus.mem_address,         32'h4);
      @(negedge clk);
      chk("stall_t2_valid", {31'h0, bus.resp_valid}, 32'h1);
      chk("stall_t2_data",  bus.resp_data,           32'h5A5AA5A5);
      held = bus.resp_data;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("stall_hold%0d_valid", k), {31'h0, bus.resp_valid}, 32'h1);
         chk($sformatf("stall_hold%0d_data", k),  bus.resp_data,           held);
         chk($sformatf("stall_hold%0d_ready", k), {31'h0, bus.req_ready},  32'h0);
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      chk("stall_done_valid", {31'h0, bus.resp_valid}, 32'h0);
      chk("stall_done_ready", {31'h0, bus.req_ready},  32'h1);

      // Misaligned word load and half store
      r0 = rd_cnt;
      w0 = wr_cnt;
      txn(LW, 32'h11, 32'h0, d, e, lat);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      chk("mis_lw_err",  {31'h0, e}, 32'h1);
      chk("mis_lw_data", d,          32'h0);
      chk("mis_lw_lat",  lat,        32'd1);
      chk("mis_lw_read", rd_cnt - r0, 32'd0);
      txn(SH, 32'h11, 32'h00001111, d, e, lat);
      chk("mis_sh_err",   {31'h0, e},  32'h1);
      chk("mis_sh_write", wr_cnt - w0, 32'd0);
      pre = 32'h5A5AA5A5;
`else
      chk("mis_lw_err",  {31'h0, e}, 32'h0);
      chk("mis_lw_data", d,          32'h5A5AA5A5);
      chk("mis_lw_lat",  lat,        32'd2);
      chk("mis_lw_read", rd_cnt - r0, 32'd1);
      txn(SH, 32'h11, 32'h00001111, d, e, lat);
      chk("mis_sh_lat",  lat,         32'd3);
      chk("mis_sh_addr", wr_addr,     32'h4);
      pre = 32'h5A5A1111;
`endif
      txn(LW, 32'h10, 32'h0, d, e, lat);
      chk("mis_after_lw", d, pre);

      // Reset arriving in the WRITE cycle of a store
      w0 = wr_cnt;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = SW;
      bus.req_addr  = 32'h10;
      bus.req_wdata = 32'h0BADF00D;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      reset_n       = 1'b0;
      @(negedge clk);
      chk("midrst_mem_write", {30'h0, bus.mem_write}, 32'h0);
      @(negedge clk);
      chk("midrst_ready_low", {31'h0, bus.req_ready}, 32'h0);
      chk("midrst_no_write",  wr_cnt - w0,            32'd0);
      chk("midrst_addr",      bus.mem_address,        32'h0);
      reset_n = 1'b1;
      txn(LW, 32'h10, 32'h0, d, e, lat);
      chk("midrst_mem_kept", d, pre);

      chk("bad_write_codes", badcode, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
